mem_wb_pipe: RTL and testbench

- Parametrised MEM/WB pipeline stage between the memory stage and register-file/HI-LO write-back.
- Carries NCH GPR write channels plus one HI/LO write.
- Adds valid/ready flow control with a 2-entry skid buffer, synchronous flush, and same-cycle write-address conflict resolution.
- Latency 1 cycle, full throughput.

---
 rtl/mem_wb_pipe.sv | 191 +++++++++++++++++++
 tb/tb_mem_wb_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage.
// Carries NCH GPR write channels plus an optional HI/LO write from the memory
// stage to write-back. A valid/ready handshake sits in front of a main entry
// and a one-deep skid entry, so in_ready comes from a register and never
// depends combinationally on out_ready. Write enables reach the outputs
// already qualified, so write-back never sees an enable on a bubble.
module mem_wb_pipe #(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int NCH     = 1,
    parameter int HILO_EN = 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*AW-1:0] in_waddr,
    input  logic [NCH-1:0]    in_wreg,
    input  logic [NCH*DW-1:0] in_wdata,
    input  logic              in_we_hilo,
    input  logic [DW-1:0]     in_wdata_hi,
    input  logic [DW-1:0]     in_wdata_lo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*AW-1:0] out_waddr,
    output logic [NCH-1:0]    out_wreg,
    output logic [NCH*DW-1:0] out_wdata,
    output logic              out_we_hilo,
    output logic [DW-1:0]     out_wdata_hi,
    output logic [DW-1:0]     out_wdata_lo,
    output logic [1:0]        occupancy
);

    // One write-back beat: everything the stage holds per entry.
    typedef struct packed {
        logic [NCH*AW-1:0] waddr;
        logic [NCH-1:0]    wreg;
        logic [NCH*DW-1:0] wdata;
        logic              we_hilo;
        logic [DW-1:0]     hi;
        logic [DW-1:0]     lo;
    } beat_t;

    localparam beat_t BEAT_ZERO = '{
        waddr:   {(NCH*AW){1'b0}},
        wreg:    {NCH{1'b0}},
        wdata:   {(NCH*DW){1'b0}},
        we_hilo: 1'b0,
        hi:      {DW{1'b0}},
        lo:      {DW{1'b0}}
    };

    // Storage
    beat_t          main_r;
    beat_t          skid_r;
    logic           main_valid_r;
    logic           skid_valid_r;
    logic           in_ready_r;
    logic [1:0]     occupancy_r;
    logic [NCH-1:0] out_wreg_r;
    logic           out_we_hilo_r;

    // Next-state and helper signals
    logic [NCH-1:0] wreg_res_s;
    beat_t          in_beat_s;
    logic           in_fire_s;
    logic           out_fire_s;
    beat_t          main_nxt_s;
    beat_t          skid_nxt_s;
    logic           main_valid_nxt_s;
    logic           skid_valid_nxt_s;
    logic [NCH-1:0] out_wreg_nxt_s;
    logic           out_we_hilo_nxt_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = main_valid_r & out_ready;

    // Same-cycle address conflict: a later channel writing the same register
    // wins, so every earlier channel with that address drops its enable.
    always_comb begin
        wreg_res_s = in_wreg;
        for (int i = 0; i < NCH; i++) begin
            for (int j = i + 1; j < NCH; j++) begin
                if (in_wreg[i] && in_wreg[j] &&
                    (in_waddr[i*AW +: AW] == in_waddr[j*AW +: AW])) begin
                    wreg_res_s[i] = 1'b0;
                end else begin
                    wreg_res_s[i] = wreg_res_s[i];
                end
            end
        end
    end

    // Build the incoming beat; the HI/LO fields are forced to zero when the path is absent.
    always_comb begin
        in_beat_s       = BEAT_ZERO;
        in_beat_s.waddr = in_waddr;
        in_beat_s.wreg  = wreg_res_s;
        in_beat_s.wdata = in_wdata;
        if (HILO_EN != 0) begin
            in_beat_s.we_hilo = in_we_hilo;
            in_beat_s.hi      = in_wdata_hi;
            in_beat_s.lo      = in_wdata_lo;
        end else begin
            in_beat_s.we_hilo = 1'b0;
            in_beat_s.hi      = {DW{1'b0}};
            in_beat_s.lo      = {DW{1'b0}};
        end
    end

    // Entry movement: flush squashes everything, otherwise the beats stay in FIFO order through main and skid.
    always_comb begin
        main_nxt_s       = main_r;
        skid_nxt_s       = skid_r;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (!main_valid_r || out_fire_s) begin
            if (skid_valid_r) begin
                // Older skid beat goes first; a new beat can only land behind it.
                main_nxt_s       = skid_r;
                main_valid_nxt_s = 1'b1;
                if (in_fire_s) begin
                    skid_nxt_s       = in_beat_s;
                    skid_valid_nxt_s = 1'b1;
                end else begin
                    skid_valid_nxt_s = 1'b0;
                end
            end else if (in_fire_s) begin
                main_nxt_s       = in_beat_s;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else if (in_fire_s) begin
            // Main is stalled: park the beat in the skid entry.
            skid_nxt_s       = in_beat_s;
            skid_valid_nxt_s = 1'b1;
        end else begin
            skid_valid_nxt_s = skid_valid_r;
        end
    end

    // Qualified enables are computed ahead of the flop so the outputs come straight from registers.
    always_comb begin
        if (main_valid_nxt_s) begin
            out_wreg_nxt_s    = main_nxt_s.wreg;
            out_we_hilo_nxt_s = main_nxt_s.we_hilo;
        end else begin
            out_wreg_nxt_s    = {NCH{1'b0}};
            out_we_hilo_nxt_s = 1'b0;
        end
    end

    // State update; payload registers are left alone by flush and cleared only by reset.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            main_r        <= BEAT_ZERO;
            skid_r        <= BEAT_ZERO;
            main_valid_r  <= 1'b0;
            skid_valid_r  <= 1'b0;
            in_ready_r    <= 1'b1;
            occupancy_r   <= 2'd0;
            out_wreg_r    <= {NCH{1'b0}};
            out_we_hilo_r <= 1'b0;
        end else begin
            main_r        <= main_nxt_s;
            skid_r        <= skid_nxt_s;
            main_valid_r  <= main_valid_nxt_s;
            skid_valid_r  <= skid_valid_nxt_s;
            in_ready_r    <= ~skid_valid_nxt_s;
            occupancy_r   <= {1'b0, main_valid_nxt_s} + {1'b0, skid_valid_nxt_s};
            out_wreg_r    <= out_wreg_nxt_s;
            out_we_hilo_r <= out_we_hilo_nxt_s;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = main_valid_r;
    assign out_waddr    = main_r.waddr;
    assign out_wreg     = out_wreg_r;
    assign out_wdata    = main_r.wdata;
    assign out_we_hilo  = out_we_hilo_r;
    assign out_wdata_hi = main_r.hi;
    assign out_wdata_lo = main_r.lo;
    assign occupancy    = occupancy_r;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a dual-channel instance with HI/LO and a
// second instance with the HI/LO path removed, both driven by the same inputs.
module tb_mem_wb_pipe;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NCH = 2;

    logic              clk;
    logic              rst_;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [NCH*AW-1:0] in_waddr;
    logic [NCH-1:0]    in_wreg;
    logic [NCH*DW-1:0] in_wdata;
    logic              in_we_hilo;
    logic [DW-1:0]     in_wdata_hi;
    logic [DW-1:0]     in_wdata_lo;
    logic              out_valid;
    logic              out_ready;
    logic [NCH*AW-1:0] out_waddr;
    logic [NCH-1:0]    out_wreg;
    logic [NCH*DW-1:0] out_wdata;
    logic              out_we_hilo;
    logic [DW-1:0]     out_wdata_hi;
    logic [DW-1:0]     out_wdata_lo;
    logic [1:0]        occupancy;

    logic              nh_in_ready;
    logic              nh_out_valid;
    logic [NCH*AW-1:0] nh_out_waddr;
    logic [NCH-1:0]    nh_out_wreg;
    logic [NCH*DW-1:0] nh_out_wdata;
    logic              nh_out_we_hilo;
    logic [DW-1:0]     nh_out_wdata_hi;
    logic [DW-1:0]     nh_out_wdata_lo;
    logic [1:0]        nh_occupancy;

    int total = 0;
    int bad   = 0;

    mem_wb_pipe #(.AW(AW), .DW(DW), .NCH(NCH), .HILO_EN(1)) u_dut (
        .clk(clk), .rst_(rst_), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_waddr(in_waddr), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_we_hilo(in_we_hilo), .in_wdata_hi(in_wdata_hi), .in_wdata_lo(in_wdata_lo),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_waddr(out_waddr), .out_wreg(out_wreg), .out_wdata(out_wdata),
        .out_we_hilo(out_we_hilo), .out_wdata_hi(out_wdata_hi), .out_wdata_lo(out_wdata_lo),
        .occupancy(occupancy)
    );

    mem_wb_pipe #(.AW(AW), .DW(DW), .NCH(NCH), .HILO_EN(0)) u_nohilo (
        .clk(clk), .rst_(rst_), .flush(flush),
        .in_valid(in_valid), .in_ready(nh_in_ready),
        .in_waddr(in_waddr), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_we_hilo(in_we_hilo), .in_wdata_hi(in_wdata_hi), .in_wdata_lo(in_wdata_lo),
        .out_valid(nh_out_valid), .out_ready(out_ready),
        .out_waddr(nh_out_waddr), .out_wreg(nh_out_wreg), .out_wdata(nh_out_wdata),
        .out_we_hilo(nh_out_we_hilo), .out_wdata_hi(nh_out_wdata_hi), .out_wdata_lo(nh_out_wdata_lo),
        .occupancy(nh_occupancy)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a1, input logic [4:0] a0,
                         input logic [1:0] we, input logic [31:0] d1, input logic [31:0] d0);
        in_valid = v;
        in_waddr = {a1, a0};
        in_wreg  = we;
        in_wdata = {d1, d0};
    endtask

    initial begin
        rst_        = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b0;
        in_we_hilo  = 1'b0;
        in_wdata_hi = 32'h0;
        in_wdata_lo = 32'h0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst_out_wreg", {62'd0, out_wreg}, 64'd0);
        chk("rst_out_wdata", out_wdata, 64'd0);
        chk("rst_out_hi", {32'd0, out_wdata_hi}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b0;

        // HI/LO write, one cycle latency
        out_ready = 1'b1;
        drive(1'b1, 5'd4, 5'd3, 2'b01, 32'h0, 32'h55);
        in_we_hilo  = 1'b1;
        in_wdata_hi = 32'hDEADBEEF;
        in_wdata_lo = 32'h12345678;
        tick();
        in_valid   = 1'b0;
        in_we_hilo = 1'b0;
        chk("hilo_valid", {63'd0, out_valid}, 64'd1);
        chk("hilo_we", {63'd0, out_we_hilo}, 64'd1);
        chk("hilo_hi", {32'd0, out_wdata_hi}, 64'hDEADBEEF);
        chk("hilo_lo", {32'd0, out_wdata_lo}, 64'h12345678);
        chk("hilo_wreg", {62'd0, out_wreg}, 64'd1);
        chk("nohilo_we", {63'd0, nh_out_we_hilo}, 64'd0);
        chk("nohilo_hi", {32'd0, nh_out_wdata_hi}, 64'd0);
        chk("nohilo_lo", {32'd0, nh_out_wdata_lo}, 64'd0);
        chk("nohilo_gpr", {32'd0, nh_out_wdata[31:0]}, 64'h55);
        tick();
        chk("hilo_bubble_valid", {63'd0, out_valid}, 64'd0);
        chk("hilo_bubble_we", {63'd0, out_we_hilo}, 64'd0);
        chk("hilo_bubble_wreg", {62'd0, out_wreg}, 64'd0);
        chk("hilo_hold_hi", {32'd0, out_wdata_hi}, 64'hDEADBEEF);

        // Streaming, 8 back-to-back beats
        for (int n = 1; n <= 8; n++) begin
            drive(1'b1, 5'(n + 8), 5'(n), 2'b11, 32'h200 + 32'(n), 32'h100 + 32'(n));
            tick();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_addr", {59'd0, out_waddr[4:0]}, 64'(n));
            chk("stream_data", {32'd0, out_wdata[31:0]}, 64'h100 + 64'(n));
            chk("stream_occ", {62'd0, occupancy}, 64'd1);
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", {63'd0, out_valid}, 64'd0);
        chk("stream_drain_occ", {62'd0, occupancy}, 64'd0);

        // Backpressure: A, B, C with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 5'd0, 5'd10, 2'b01, 32'h0, 32'hA);
        tick();
        chk("bp_a_occ", {62'd0, occupancy}, 64'd1);
        chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 5'd0, 5'd11, 2'b01, 32'h0, 32'hB);
        tick();
        chk("bp_b_occ", {62'd0, occupancy}, 64'd2);
        chk("bp_b_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_b_main", {32'd0, out_wdata[31:0]}, 64'hA);
        drive(1'b1, 5'd0, 5'd12, 2'b01, 32'h0, 32'hC);
        tick();
        chk("bp_c_occ", {62'd0, occupancy}, 64'd2);
        chk("bp_c_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_c_main", {32'd0, out_wdata[31:0]}, 64'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_b", {32'd0, out_wdata[31:0]}, 64'hB);
        chk("bp_rel_b_occ", {62'd0, occupancy}, 64'd1);
        chk("bp_rel_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_rel_c", {32'd0, out_wdata[31:0]}, 64'hC);
        chk("bp_rel_c_addr", {59'd0, out_waddr[4:0]}, 64'd12);
        chk("bp_rel_c_valid", {63'd0, out_valid}, 64'd1);
        tick();
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Flush with two beats held and an incoming beat
        out_ready = 1'b0;
        drive(1'b1, 5'd0, 5'd20, 2'b01, 32'h0, 32'hD);
        in_we_hilo = 1'b1;
        tick();
        drive(1'b1, 5'd0, 5'd21, 2'b01, 32'h0, 32'hE);
        tick();
        chk("fl_pre_occ", {62'd0, occupancy}, 64'd2);
        drive(1'b1, 5'd0, 5'd22, 2'b01, 32'h0, 32'hF);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_we_hilo = 1'b0;
        chk("fl_occ", {62'd0, occupancy}, 64'd0);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_wreg", {62'd0, out_wreg}, 64'd0);
        chk("fl_we_hilo", {63'd0, out_we_hilo}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        chk("fl_payload_hold", {32'd0, out_wdata[31:0]}, 64'hD);
        tick();
        chk("fl_stays_empty", {63'd0, out_valid}, 64'd0);

        // Flush with one beat held and an accepted incoming beat
        out_ready = 1'b0;
        drive(1'b1, 5'd0, 5'd23, 2'b01, 32'h0, 32'h17);
        tick();
        drive(1'b1, 5'd0, 5'd24, 2'b01, 32'h0, 32'h18);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl1_occ", {62'd0, occupancy}, 64'd0);
        chk("fl1_valid", {63'd0, out_valid}, 64'd0);

        // Address conflict and address 0
        out_ready = 1'b1;
        drive(1'b1, 5'd5, 5'd5, 2'b11, 32'hBBBB, 32'hAAAA);
        tick();
        chk("cf_same_wreg", {62'd0, out_wreg}, 64'b10);
        chk("cf_same_d1", {32'd0, out_wdata[63:32]}, 64'hBBBB);
        drive(1'b1, 5'd6, 5'd5, 2'b11, 32'hBBBB, 32'hAAAA);
        tick();
        chk("cf_diff_wreg", {62'd0, out_wreg}, 64'b11);
        drive(1'b1, 5'd5, 5'd5, 2'b01, 32'hBBBB, 32'hAAAA);
        tick();
        chk("cf_one_en_wreg", {62'd0, out_wreg}, 64'b01);
        drive(1'b1, 5'd7, 5'd0, 2'b01, 32'h0, 32'h99);
        tick();
        chk("r0_wreg", {62'd0, out_wreg}, 64'b01);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset with two beats held
        out_ready = 1'b0;
        drive(1'b1, 5'd0, 5'd1, 2'b01, 32'h0, 32'h1);
        tick();
        drive(1'b1, 5'd0, 5'd2, 2'b01, 32'h0, 32'h2);
        tick();
        chk("ar_pre_occ", {62'd0, occupancy}, 64'd2);
        in_valid = 1'b0;
        rst_ = 1'b1;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_wreg", {62'd0, out_wreg}, 64'd0);
        chk("ar_occ", {62'd0, occupancy}, 64'd0);
        chk("ar_ready", {63'd0, in_ready}, 64'd1);
        chk("ar_wdata", out_wdata, 64'd0);
        #1;
        rst_ = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 5'd0, 5'd9, 2'b01, 32'h0, 32'h909);
        tick();
        in_valid = 1'b0;
        chk("ar_first_valid", {63'd0, out_valid}, 64'd1);
        chk("ar_first_data", {32'd0, out_wdata[31:0]}, 64'h909);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
